lcd_text_sequencer: RTL and testbench

//  Parametrised LCD frame sequencer for HD44780-class displays. Runs the power-up init

---
 rtl/lcd_text_sequencer.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_lcd_text_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_text_sequencer.sv
// -----------------------------------------------------------------------------
// lcd_text_sequencer
//
// Frame sequencer for HD44780-class character LCDs. After reset the first
// frame starts with the four power-up commands (0x38, 0x0C, 0x01, 0x06). Every
// frame then paints ROWS x COLS characters. Each row begins with a DDRAM
// address command, and its characters are fetched from a synchronous text RAM.
// Every byte is handed to a byte-level write controller with a one-cycle
// lcd_start_o pulse. The sequencer then waits for lcd_done_i, followed by
// DLY_CYCLES idle cycles.
//
// Item flow per byte: LOAD -> ISSUE -> WAIT -> GAP -> NEXT.
//
// Optional feature (macro LCD_SEQ_CLEAR_EN): when defined, every frame that
// starts with init_done_o=1 first sends a clear-display command (0x01).
//
// Parameters
//   COLS        characters per row (1..40)
//   ROWS        display rows (1..4)
//   DLY_CYCLES  idle cycles after every lcd_done_i (>= 1)
//   MEM_LAT     text RAM read latency in cycles (0..3)
//   AW          mem_addr_o width, derived from ROWS*COLS
//
// Ports
//   clk_i         system clock, rising edge
//   rst_ni        asynchronous active-low reset
//   start_i       level; sampled only in IDLE, launches one frame
//   mem_data_i    character byte from the text RAM
//   lcd_done_i    one-cycle pulse: byte write complete (used only in WAIT)
//   mem_addr_o    text RAM address, row*COLS+col
//   lcd_start_o   one-cycle pulse launching a byte write
//   lcd_data_o    byte to write, stable from lcd_start_o until lcd_done_i
//   lcd_rs_o      0 = command, 1 = character
//   busy_o        high in every state except IDLE
//   init_done_o   set after the init commands; cleared only by reset
//   frame_done_o  one-cycle pulse after the last character's delay
// -----------------------------------------------------------------------------
module lcd_text_sequencer #(
    parameter int COLS       = 16,
    parameter int ROWS       = 2,
    parameter int DLY_CYCLES = 262142,
    parameter int MEM_LAT    = 1,
    localparam int AW        = (ROWS * COLS > 1) ? $clog2(ROWS * COLS) : 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic [7:0]    mem_data_i,
    input  logic          lcd_done_i,
    output logic [AW-1:0] mem_addr_o,
    output logic          lcd_start_o,
    output logic [7:0]    lcd_data_o,
    output logic          lcd_rs_o,
    output logic          busy_o,
    output logic          init_done_o,
    output logic          frame_done_o
);

    localparam int DW       = (DLY_CYCLES > 1) ? $clog2(DLY_CYCLES + 1) : 1;
    localparam int LOAD_CYC = (MEM_LAT < 1) ? 1 : MEM_LAT;

    localparam logic [DW-1:0] DLY_LAST = DW'(DLY_CYCLES - 1);
    localparam logic [1:0]    LAT_LAST = 2'(LOAD_CYC - 1);
    localparam logic [5:0]    COL_LAST = 6'(COLS - 1);
    localparam logic [1:0]    ROW_LAST = 2'(ROWS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_GAP,
        S_NEXT
    } state_e;

    // Which kind of item the sequencer is currently working on
    typedef enum logic [1:0] {
        PH_INIT,
        PH_CLR,
        PH_ADDR,
        PH_CHAR
    } phase_e;

`ifdef LCD_SEQ_CLEAR_EN
    localparam phase_e FRAME_PH = PH_CLR;
`else
    localparam phase_e FRAME_PH = PH_ADDR;
`endif

    state_e          state_q,      state_d;
    phase_e          phase_q,      phase_d;
    logic [1:0]      init_idx_q,   init_idx_d;
    logic [1:0]      row_q,        row_d;
    logic [5:0]      col_q,        col_d;
    logic [1:0]      lat_q,        lat_d;
    logic [DW-1:0]   dly_q,        dly_d;
    logic [AW-1:0]   mem_addr_q,   mem_addr_d;
    logic            lcd_start_q,  lcd_start_d;
    logic [7:0]      lcd_data_q,   lcd_data_d;
    logic            lcd_rs_q,     lcd_rs_d;
    logic            busy_q,       busy_d;
    logic            init_done_q,  init_done_d;
    logic            frame_done_q, frame_done_d;

    // DDRAM set-address command for each row: 0x80 | {0x00, 0x40, COLS, 0x40+COLS}
    logic [7:0] row_cmd [4];
    for (genvar gi = 0; gi < 4; gi++) begin : g_row_cmd
        localparam int BASE = (gi == 0) ? 'h00 :
                              (gi == 1) ? 'h40 :
                              (gi == 2) ? COLS : ('h40 + COLS);
        assign row_cmd[gi] = 8'h80 | 8'(BASE);
    end

    logic [7:0] cmd_byte;
    always_comb begin
        cmd_byte = 8'h00;
        case (phase_q)
            PH_INIT: begin
                case (init_idx_q)
                    2'd0:    cmd_byte = 8'h38;
                    2'd1:    cmd_byte = 8'h0C;
                    2'd2:    cmd_byte = 8'h01;
                    default: cmd_byte = 8'h06;
                endcase
            end
            PH_CLR:  cmd_byte = 8'h01;
            PH_ADDR: cmd_byte = row_cmd[row_q];
            default: cmd_byte = 8'h00;
        endcase
    end

    logic is_char;
    logic last_char;
    assign is_char   = (phase_q == PH_CHAR);
    assign last_char = is_char && (row_q == ROW_LAST) && (col_q == COL_LAST);

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        init_idx_d   = init_idx_q;
        row_d        = row_q;
        col_d        = col_q;
        lat_d        = lat_q;
        dly_d        = dly_q;
        mem_addr_d   = mem_addr_q;
        lcd_start_d  = 1'b0;
        lcd_data_d   = lcd_data_q;
        lcd_rs_d     = lcd_rs_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_LOAD;
                    phase_d    = init_done_q ? FRAME_PH : PH_INIT;
                    init_idx_d = 2'd0;
                    row_d      = 2'd0;
                    col_d      = 6'd0;
                    lat_d      = 2'd0;
                    mem_addr_d = '0;
                end
            end

            S_LOAD: begin
                // Characters stay here for the RAM latency. Commands take one cycle.
                if (is_char && lat_q != LAT_LAST) begin
                    lat_d = lat_q + 2'd1;
                end else begin
                    lat_d       = 2'd0;
                    state_d     = S_ISSUE;
                    lcd_start_d = 1'b1;
                    lcd_data_d  = is_char ? mem_data_i : cmd_byte;
                    lcd_rs_d    = is_char;
                end
            end

            S_ISSUE: state_d = S_WAIT;

            S_WAIT: begin
                if (lcd_done_i) begin
                    state_d = S_GAP;
                    dly_d   = '0;
                end
            end

            S_GAP: begin
                if (dly_q == DLY_LAST) begin
                    state_d = S_NEXT;
                    dly_d   = '0;
                    // Characters are fetched in linear order across rows.
                    // Advancing here presents the next address from NEXT
                    // onward, which gives the RAM its full latency inside LOAD.
                    if (is_char && !last_char) begin
                        mem_addr_d = mem_addr_q + AW'(1);
                    end
                end else begin
                    dly_d = dly_q + DW'(1);
                end
            end

            S_NEXT: begin
                state_d = S_LOAD;
                case (phase_q)
                    PH_INIT: begin
                        if (init_idx_q == 2'd3) begin
                            init_done_d = 1'b1;
                            phase_d     = PH_ADDR;
                        end else begin
                            init_idx_d = init_idx_q + 2'd1;
                        end
                    end
                    PH_CLR:  phase_d = PH_ADDR;
                    PH_ADDR: begin
                        phase_d = PH_CHAR;
                        col_d   = 6'd0;
                    end
                    default: begin
                        if (col_q == COL_LAST) begin
                            col_d = 6'd0;
                            if (row_q == ROW_LAST) begin
                                row_d        = 2'd0;
                                frame_done_d = 1'b1;
                                state_d      = S_IDLE;
                            end else begin
                                row_d   = row_q + 2'd1;
                                phase_d = PH_ADDR;
                            end
                        end else begin
                            col_d = col_q + 6'd1;
                        end
                    end
                endcase
            end

            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            phase_q      <= PH_INIT;
            init_idx_q   <= 2'd0;
            row_q        <= 2'd0;
            col_q        <= 6'd0;
            lat_q        <= 2'd0;
            dly_q        <= '0;
            mem_addr_q   <= '0;
            lcd_start_q  <= 1'b0;
            lcd_data_q   <= 8'h00;
            lcd_rs_q     <= 1'b0;
            busy_q       <= 1'b0;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            init_idx_q   <= init_idx_d;
            row_q        <= row_d;
            col_q        <= col_d;
            lat_q        <= lat_d;
            dly_q        <= dly_d;
            mem_addr_q   <= mem_addr_d;
            lcd_start_q  <= lcd_start_d;
            lcd_data_q   <= lcd_data_d;
            lcd_rs_q     <= lcd_rs_d;
            busy_q       <= busy_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign mem_addr_o   = mem_addr_q;
    assign lcd_start_o  = lcd_start_q;
    assign lcd_data_o   = lcd_data_q;
    assign lcd_rs_o     = lcd_rs_q;
    assign busy_o       = busy_q;
    assign init_done_o  = init_done_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: tb/tb_lcd_text_sequencer.sv
// -----------------------------------------------------------------------------
// Testbench for lcd_text_sequencer. It uses a 20x4 geometry, DLY_CYCLES=10 and
// MEM_LAT=3.
//
// The text RAM model has a three-stage read pipeline, and each entry holds
// addr^0xA5. The byte-controller model answers every lcd_start_o with
// lcd_done_i five cycles later.
//
// The expected write stream of each frame is pushed to a scoreboard queue when
// start is driven. Every lcd_start_o pops one entry and checks the data byte,
// rs, mem_addr and the spacing from the previous lcd_done.
// -----------------------------------------------------------------------------
module tb_lcd_text_sequencer;

    localparam int COLS = 20;
    localparam int ROWS = 4;
    localparam int DLY  = 10;
    localparam int LAT  = 3;
    localparam int AW   = $clog2(ROWS * COLS);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          lcd_done = 1'b0;
    logic [7:0]    mem_data;
    logic [AW-1:0] mem_addr;
    logic          lcd_start;
    logic [7:0]    lcd_data;
    logic          lcd_rs;
    logic          busy;
    logic          init_done;
    logic          frame_done;

    lcd_text_sequencer #(
        .COLS       (COLS),
        .ROWS       (ROWS),
        .DLY_CYCLES (DLY),
        .MEM_LAT    (LAT)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .mem_data_i   (mem_data),
        .lcd_done_i   (lcd_done),
        .mem_addr_o   (mem_addr),
        .lcd_start_o  (lcd_start),
        .lcd_data_o   (lcd_data),
        .lcd_rs_o     (lcd_rs),
        .busy_o       (busy),
        .init_done_o  (init_done),
        .frame_done_o (frame_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Text RAM: contents addr^0xA5, read latency LAT (three pipeline stages)
    logic [7:0] ram [ROWS*COLS];
    logic [7:0] p1, p2, p3;
    initial begin
        for (int i = 0; i < ROWS * COLS; i++) ram[i] = 8'(i) ^ 8'hA5;
    end
    always @(posedge clk) begin
        p1 <= ram[mem_addr];
        p2 <= p1;
        p3 <= p2;
    end
    assign mem_data = p3;

    // Checking
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Scoreboard
    typedef struct {
        logic       rs;
        logic [7:0] data;
        int         addr;   // -1 for commands
        int         gap;    // cycles from previous lcd_done; 0 = not checked
    } item_t;

    item_t sb[$];
    bit    first_item;

    task automatic push(input logic rs, input logic [7:0] data, input int addr, input int gap);
        item_t it;
        it.rs   = rs;
        it.data = data;
        it.addr = addr;
        it.gap  = first_item ? 0 : gap;
        first_item = 1'b0;
        sb.push_back(it);
    endtask

    task automatic push_frame(input bit with_init);
        logic [7:0] init_cmds [4];
        logic [7:0] base;
        init_cmds[0] = 8'h38;
        init_cmds[1] = 8'h0C;
        init_cmds[2] = 8'h01;
        init_cmds[3] = 8'h06;
        first_item = 1'b1;
        if (with_init) begin
            for (int k = 0; k < 4; k++) push(1'b0, init_cmds[k], -1, DLY + 3);
        end
`ifdef LCD_SEQ_CLEAR_EN
        else push(1'b0, 8'h01, -1, DLY + 3);
`endif
        for (int r = 0; r < ROWS; r++) begin
            base = (r == 0) ? 8'h00 : (r == 1) ? 8'h40 : (r == 2) ? 8'(COLS) : 8'(8'h40 + COLS);
            push(1'b0, 8'h80 | base, -1, DLY + 3);
            for (int c = 0; c < COLS; c++) begin
                push(1'b1, 8'(r * COLS + c) ^ 8'hA5, r * COLS + c, DLY + 2 + LAT);
            end
        end
    endtask

    // Byte controller model: lcd_done five cycles after lcd_start, optional
    // stray done pulse inside the following GAP
    bit resp_en   = 1'b1;
    bit stray_gap = 1'b0;
    int last_done_cyc = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (lcd_start && resp_en) begin
                repeat (5) @(negedge clk);
                lcd_done = 1'b1;
                last_done_cyc = cyc;
                @(negedge clk);
                lcd_done = 1'b0;
                if (stray_gap) begin
                    repeat (3) @(negedge clk);
                    lcd_done = 1'b1;
                    @(negedge clk);
                    lcd_done = 1'b0;
                end
            end
        end
    end

    // Monitor: pop and compare on every lcd_start, check frame_done width
    logic prev_fd = 1'b0;
    initial begin
        item_t it;
        forever begin
            @(negedge clk);
            if (lcd_start) begin
                $display("txn t=%0t rs=%0d data=%02h addr=%0d", $time, lcd_rs, lcd_data, mem_addr);
                chk("sb_has_item", 32'(sb.size() > 0), 32'd1);
                if (sb.size() > 0) begin
                    it = sb.pop_front();
                    chk("lcd_data", 32'(lcd_data), 32'(it.data));
                    chk("lcd_rs", 32'(lcd_rs), 32'(it.rs));
                    if (it.addr >= 0) chk("mem_addr", 32'(mem_addr), 32'(it.addr));
                    if (it.gap > 0) chk("done_to_start", 32'(cyc - last_done_cyc), 32'(it.gap));
                end
            end
            if (frame_done) chk("frame_done_width", 32'(prev_fd), 32'd0);
            prev_fd = frame_done;
        end
    end

    task automatic wait_frame();
        int k = 0;
        while (!frame_done && k < 6000) begin
            @(negedge clk);
            k++;
        end
        chk("frame_done_seen", 32'(frame_done), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic stray_idle_done();
        lcd_done = 1'b1;
        @(negedge clk);
        lcd_done = 1'b0;
        repeat (3) @(negedge clk);
        chk("idle_stray_busy", 32'(busy), 32'd0);
    endtask

    initial begin
        int k;

        // Reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_lcd_start", 32'(lcd_start), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_lcd_data", 32'(lcd_data), 32'd0);
        chk("rst_lcd_rs", 32'(lcd_rs), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        stray_idle_done();

        // Frame 1: init commands plus full paint
        push_frame(1'b1);
        pulse_start();
        wait_frame();
        @(negedge clk);
        chk("f1_init_done", 32'(init_done), 32'd1);
        chk("f1_sb_empty", 32'(sb.size()), 32'd0);
        chk("f1_idle", 32'(busy), 32'd0);

        // Frame 2: no init; stray lcd_done inside every GAP
        stray_gap = 1'b1;
        push_frame(1'b0);
        pulse_start();
        wait_frame();
        stray_gap = 1'b0;
        @(negedge clk);
        chk("f2_sb_empty", 32'(sb.size()), 32'd0);

        // Back-to-back frames with start held high
        push_frame(1'b0);
        push_frame(1'b0);
        start = 1'b1;
        wait_frame();
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("b2b_relaunch_busy", 32'(busy), 32'd1);
        wait_frame();
        @(negedge clk);
        chk("b2b_sb_empty", 32'(sb.size()), 32'd0);
        chk("b2b_idle", 32'(busy), 32'd0);

        // Reset during character 7 of row 1
        push_frame(1'b0);
        pulse_start();
        k = 0;
        while (!(lcd_start && mem_addr == AW'(COLS + 7)) && k < 6000) begin
            @(negedge clk);
            k++;
        end
        chk("reached_row1_char7", 32'(lcd_start), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_init_done", 32'(init_done), 32'd0);
        chk("arst_lcd_start", 32'(lcd_start), 32'd0);
        chk("arst_mem_addr", 32'(mem_addr), 32'd0);
        chk("arst_lcd_data", 32'(lcd_data), 32'd0);
        chk("arst_lcd_rs", 32'(lcd_rs), 32'd0);
        sb.delete();
        repeat (12) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        stray_idle_done();

        // Re-run after reset: init sequence again
        push_frame(1'b1);
        pulse_start();
        wait_frame();
        @(negedge clk);
        chk("rerun_init_done", 32'(init_done), 32'd1);
        chk("rerun_sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
